// File: rtl/carry_skip_adder_if.sv
// Operand/result bundle for the registered carry-skip adder.
// The master drives operands and carry-in; the slave returns the registered sum and carry.
interface carry_skip_adder_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             carry;

    modport master (
        output a,
        output b,
        output cin,
        input  sum,
        input  carry
    );

    modport slave (
        input  a,
        input  b,
        input  cin,
        output sum,
        output carry
    );
endinterface

// File: rtl/carry_skip_adder.sv
// Registered WIDTH-bit adder built from BLOCK-bit ripple groups with per-group carry bypass.
// {carry, sum} is a + b + cin one clock after the operands are presented.
module carry_skip_adder #(
    parameter int WIDTH = 4,
    parameter int BLOCK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    carry_skip_adder_if.slave   bus
);
    localparam int NGRP = (WIDTH + BLOCK - 1) / BLOCK;

    logic [WIDTH-1:0] p_s;
    logic [WIDTH-1:0] g_s;
    logic [WIDTH-1:0] sum_s;
    logic [NGRP:0]    gc_s;

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             carry_d;
    logic             carry_q;

    assign p_s     = bus.a ^ bus.b;
    assign g_s     = bus.a & bus.b;
    assign gc_s[0] = bus.cin;

    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        localparam int LO = k * BLOCK;
        localparam int HI = (((LO + BLOCK) > WIDTH) ? WIDTH : (LO + BLOCK)) - 1;
        localparam int GW = HI - LO + 1;

        logic [GW:0] rc_s;

        assign rc_s[0] = gc_s[k];

        for (genvar j = 0; j < GW; j++) begin : g_bit
            assign rc_s[j+1]    = g_s[LO+j] | (p_s[LO+j] & rc_s[j]);
            assign sum_s[LO+j]  = p_s[LO+j] ^ rc_s[j];
        end

        // Skip mux: a fully propagating group passes its carry-in straight through.
        assign gc_s[k+1] = (&p_s[HI:LO]) ? gc_s[k] : rc_s[GW];
    end

    // Next-state for the result registers, cleared while reset is held.
    always_comb begin
        sum_d   = {WIDTH{1'b0}};
        carry_d = 1'b0;
        if (!rst_n) begin
            sum_d   = {WIDTH{1'b0}};
            carry_d = 1'b0;
        end else begin
            sum_d   = sum_s;
            carry_d = gc_s[NGRP];
        end
    end

    // Result registers.
    always_ff @(posedge clk) begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
    end

    assign bus.sum   = sum_q;
    assign bus.carry = carry_q;
endmodule

// File: tb/tb_carry_skip_adder.sv
// Directed and exhaustive bench for carry_skip_adder: a 4-bit unit under directed steps plus
// six 8-bit units (BLOCK 2/3/4, cin 0/1) swept over every a/b pair, all checked via a scoreboard.
module tb_carry_skip_adder;
    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] wa;
    logic [7:0] wb;

    always #5 clk = ~clk;

    carry_skip_adder_if #(.WIDTH(4)) cif ();

    carry_skip_adder #(.WIDTH(4), .BLOCK(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (cif)
    );

    logic [8:0] wobs [0:5];

    for (genvar gi = 0; gi < 6; gi++) begin : g_wide
        carry_skip_adder_if #(.WIDTH(8)) wif ();
        assign wif.a   = wa;
        assign wif.b   = wb;
        assign wif.cin = ((gi % 2) == 1) ? 1'b1 : 1'b0;
        carry_skip_adder #(.WIDTH(8), .BLOCK(2 + gi / 2)) u_w (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (wif)
        );
        assign wobs[gi] = {wif.carry, wif.sum};
    end

    typedef struct {
        logic [4:0] m;
        logic [8:0] w0;
        logic [8:0] w1;
    } exp_t;

    exp_t sbq [$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_push(input logic r, input logic [3:0] ta, input logic [3:0] tb_,
                              input logic tc, input logic [4:0] em,
                              input logic [7:0] twa, input logic [7:0] twb);
        exp_t e;
        rst_n   = r;
        cif.a   = ta;
        cif.b   = tb_;
        cif.cin = tc;
        wa      = twa;
        wb      = twb;
        e.m     = r ? em : 5'd0;
        e.w0    = r ? ({1'b0, twa} + {1'b0, twb}) : 9'd0;
        e.w1    = r ? ({1'b0, twa} + {1'b0, twb} + 9'd1) : 9'd0;
        sbq.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sbq.pop_front();
            chk("main", {4'd0, cif.carry, cif.sum}, {4'd0, e.m});
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("wide_b%0d_cin%0d", 2 + i / 2, i % 2), wobs[i],
                    ((i % 2) == 1) ? e.w1 : e.w0);
            end
        end
    endtask

    task automatic step(input logic r, input logic [3:0] ta, input logic [3:0] tb_,
                        input logic tc, input logic [4:0] em,
                        input logic [7:0] twa, input logic [7:0] twb);
        @(negedge clk);
        pop_check();
        drive_push(r, ta, tb_, tc, em, twa, twb);
    endtask

    task automatic rstep(input logic r);
        logic [3:0] ta;
        logic [3:0] tb_;
        logic       tc;
        ta  = 4'($urandom_range(0, 15));
        tb_ = 4'($urandom_range(0, 15));
        tc  = 1'($urandom_range(0, 1));
        step(r, ta, tb_, tc, {1'b0, ta} + {1'b0, tb_} + {4'd0, tc},
             8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    endtask

    initial begin
        // Reset held for two edges with all-ones operands, then released.
        drive_push(1'b0, 4'hF, 4'hF, 1'b1, 5'h1F, 8'h00, 8'h00);
        step(1'b0, 4'hF, 4'hF, 1'b1, 5'h1F, 8'hFF, 8'hFF);
        step(1'b1, 4'hF, 4'hF, 1'b1, 5'b11111, 8'hFF, 8'hFF);

        // Directed vectors with expected {carry, sum} written out.
        step(1'b1, 4'b1000, 4'b0011, 1'b0, 5'b01011, 8'h80, 8'h7F);
        step(1'b1, 4'b0001, 4'b1010, 1'b1, 5'b01100, 8'hFF, 8'h01);
        step(1'b1, 4'b0110, 4'b0110, 1'b0, 5'b01100, 8'h00, 8'h00);
        step(1'b1, 4'b0111, 4'b1110, 1'b0, 5'b10101, 8'hAA, 8'h55);
        step(1'b1, 4'b1001, 4'b0100, 1'b0, 5'b01101, 8'h0F, 8'hF0);
        step(1'b1, 4'b1111, 4'b1110, 1'b1, 5'b11110, 8'hC3, 8'h3C);
        step(1'b1, 4'b1001, 4'b0110, 1'b1, 5'b10000, 8'h5A, 8'hA5);
        step(1'b1, 4'b1001, 4'b0110, 1'b0, 5'b01111, 8'h12, 8'h34);
        step(1'b1, 4'b1111, 4'b1111, 1'b1, 5'b11111, 8'hFF, 8'hFF);
        step(1'b1, 4'b0000, 4'b0000, 1'b0, 5'b00000, 8'h00, 8'h00);

        // Back-to-back stream, then a one-edge reset in the middle of another stream.
        for (int i = 0; i < 8; i++) rstep(1'b1);
        rstep(1'b1);
        rstep(1'b1);
        rstep(1'b0);
        rstep(1'b1);
        rstep(1'b1);

        // Exhaustive 8-bit sweep on the wide units while the 4-bit unit keeps streaming.
        for (int x = 0; x < 256 && errors < 50; x++) begin
            for (int y = 0; y < 256 && errors < 50; y++) begin
                logic [3:0] ta;
                logic [3:0] tb_;
                logic       tc;
                ta  = 4'($urandom_range(0, 15));
                tb_ = 4'($urandom_range(0, 15));
                tc  = 1'($urandom_range(0, 1));
                step(1'b1, ta, tb_, tc, {1'b0, ta} + {1'b0, tb_} + {4'd0, tc}, 8'(x), 8'(y));
            end
        end

        @(negedge clk);
        pop_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
